noc_demux_1ton: RTL and testbench
=================================

Name: noc_demux_1toN

Overview:
- Parametrised, flit-level 1-to-N demultiplexer with valid/ready handshake and per-output buffering.
- Routes a packet of flits from one input to the output selected by the head flit's select field.
- Holds that route until the tail flit is accepted (wormhole-style lock).
- Sits between the router input stage and the per-port output links of the NoC; successor to the combinational 1-to-4 bit demux.

Parameters:
- DATA_W, 32, flit payload width in bits
- NUM_OUT, 4, number of output ports (2..16)
- SEL_W, $clog2(NUM_OUT), width of the select field (derived; do not override)
- FIFO_DEPTH, 2, entries per output FIFO (power of two, >= 2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  DATA_W  input flit payload
- in_sel  input  SEL_W  destination port; sampled on head flits only
- in_last  input  1  tail-flit marker; a single-flit packet has in_last=1 on its head
- in_valid  input  1  input flit valid
- in_ready  output  1  input flit accepted when in_valid && in_ready
- out_data  output  NUM_OUT*DATA_W  packed payloads; port k occupies bits [k*DATA_W +: DATA_W]
- out_last  output  NUM_OUT  per-port tail marker
- out_valid  output  NUM_OUT  per-port flit valid
- out_ready  input  NUM_OUT  per-port downstream ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: FSM=IDLE, all FIFOs empty, out_valid=0, out_last=0, out_data=0, in_ready=0 while rst is asserted.
- FSM IDLE:
  - The target is in_sel.
  - On acceptance with in_last=0: latch lock_sel=in_sel and go to LOCKED.
  - On acceptance with in_last=1: stay in IDLE.
- FSM LOCKED:
  - The target is lock_sel; in_sel is ignored.
  - On accepting a flit with in_last=1: return to IDLE.
- Out-of-range select (in_sel >= NUM_OUT, only possible when NUM_OUT is not a power of two), IDLE only:
  - in_ready=1, the flit is accepted and discarded.
  - A discarded head with in_last=0 goes to the DROP state. DROP discards flits (in_ready=1) until the tail is accepted, then returns to IDLE.
- in_ready = !full(target FIFO); in DROP, in_ready=1.
  - There is no combinational path from out_ready to in_ready.
  - Consequence: no push into a full FIFO even if that FIFO pops in the same cycle.
- Push: {in_last,in_data} is written into the target FIFO on acceptance.
- Latency: a flit accepted in cycle t is visible on out_* in cycle t+1. Minimum latency is 1 cycle.
- Pop: each port pops independently when out_valid[k] && out_ready[k].
- out_valid[k] = !empty(k). out_data and out_last are driven from the FIFO head (registered/readout, no bubble).
- Per-port throughput is 1 flit/cycle when out_ready is held high.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are derived from a count register of width $clog2(FIFO_DEPTH)+1.
- Non-target ports are unaffected and keep draining while another port is locked.
- rst asserted mid-packet: FIFOs flushed, partial packets lost, FSM returns to IDLE; no flit is emitted after rst deasserts until new input arrives.
- out_valid must not deassert without a pop; out_data and out_last stay stable while out_valid && !out_ready.

Optional Feature:
- Macro: NOC_DEMUX_DROP_CNT_EN.
- With the macro defined:
  - Extra output port drop_cnt (output, 16 bits).
  - drop_cnt increments on every discarded flit and saturates at 16'hFFFF.
  - drop_cnt resets to 0.
- Without the macro: the port and counter are absent. Discarding behaviour is identical.

Decomposition:
- Package noc_demux_pkg holds:
  - state enum {IDLE, LOCKED, DROP} (2-bit)
  - localparam DROP_CNT_W=16
  - clog2 helper function if one is not already shared
- One sub-module, demux_fifo: a synchronous FIFO with async active-high reset, parameters WIDTH and DEPTH, interface push/pop/full/empty/head. Instantiated NUM_OUT times via generate.

Test Plan:
- Single-flit packets: in_sel=2, in_last=1, data 0xA5A5_0001 -> out_valid[2]=1 next cycle with that data and out_last[2]=1; other ports idle.
- 4-flit packet:
  - head in_sel=1, body flits in_sel=3, tail in_last=1 -> all 4 flits appear on port 1 in order; out_last set only on flit 4.
  - A following head with in_sel=3 goes to port 3.
- Backpressure: out_ready[0]=0, send 3 flits to port 0 with FIFO_DEPTH=2 -> in_ready drops after 2 accepts. Raise out_ready -> flits drain in order, the third is accepted, nothing lost or duplicated.
- Parallel drain: port 0 full and stalled, then a packet to port 1 -> port 1 flits are accepted and delivered at 1/cycle while port 0 holds data stable.
- NUM_OUT=3, in_sel=3, 2-flit packet -> both flits accepted and discarded, no out_valid. With NOC_DEMUX_DROP_CNT_EN, drop_cnt=2.
- Reset mid-packet: assert rst after flit 2 of 4 -> out_valid=0 immediately (async). After release, a head with in_sel=0 routes to port 0, showing the FSM is back in IDLE.

Source files
------------

// File: rtl/noc_demux_pkg.sv
// Shared types and constants for the 1-to-N flit demultiplexer.
package noc_demux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        DROP   = 2'd2
    } state_e;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/noc_demux_fifo.sv
// demux_fifo: synchronous FIFO with count-based full/empty and a zeroed head when empty.
module demux_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Storage is not reset, so the head is forced to zero while nothing is queued.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/noc_demux_1ton.sv
// noc_demux_1ton: wormhole-locked 1-to-N flit demux with a FIFO per output port.
// Optional NOC_DEMUX_DROP_CNT_EN adds a saturating drop_cnt output for discarded flits.
module noc_demux_1ton
    import noc_demux_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_OUT    = 4,
    parameter int SEL_W      = $clog2(NUM_OUT),
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_last,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready
`ifdef NOC_DEMUX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]     drop_cnt
`endif
);
    localparam logic [SEL_W:0] NUM_OUT_V = (SEL_W + 1)'(NUM_OUT);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] lock_sel_q, lock_sel_d;
    logic [SEL_W-1:0] tgt;
    logic             in_range;
    logic             discard;
    logic             tgt_full;
    logic             accept;
    logic [NUM_OUT-1:0] fifo_push;
    logic [NUM_OUT-1:0] fifo_full;
    logic [NUM_OUT-1:0] fifo_empty;
    logic [DATA_W:0]    fifo_head [NUM_OUT];

    // in_ready depends only on FIFO fill state, never on out_ready.
    always_comb begin
        tgt       = (state_q == LOCKED) ? lock_sel_q : in_sel;
        in_range  = ({1'b0, tgt} < NUM_OUT_V);
        discard   = (state_q == DROP) || ((state_q == IDLE) && !in_range);
        tgt_full  = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (tgt == SEL_W'(k)) begin
                tgt_full = fifo_full[k];
            end
        end
        in_ready  = !rst && (discard || !tgt_full);
        accept    = in_valid && in_ready;
        fifo_push = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            fifo_push[k] = accept && !discard && (tgt == SEL_W'(k));
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        case (state_q)
            IDLE: begin
                if (accept && !in_last) begin
                    state_d    = in_range ? LOCKED : DROP;
                    lock_sel_d = in_sel;
                end
            end
            LOCKED, DROP: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_port
        demux_fifo #(
            .WIDTH(DATA_W + 1),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push_i (fifo_push[g]),
            .wdata_i({in_last, in_data}),
            .pop_i  (out_ready[g]),
            .full_o (fifo_full[g]),
            .empty_o(fifo_empty[g]),
            .head_o (fifo_head[g])
        );

        assign out_valid[g]                   = !fifo_empty[g];
        assign out_last[g]                    = fifo_head[g][DATA_W];
        assign out_data[g*DATA_W +: DATA_W]   = fifo_head[g][DATA_W-1:0];
    end

`ifdef NOC_DEMUX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (accept && discard && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_noc_demux_1ton.sv
// Bench for noc_demux_1ton: a 4-port and a 3-port instance checked against a queue-based packet model.
module tb_noc_demux_1ton;
    localparam int DW = 32;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_last;
    logic          in_valid;
    logic [3:0]    out_ready;
    logic          use3;

    logic          rdy4;
    logic [4*DW-1:0] od4;
    logic [3:0]    ol4, ov4;
    logic          rdy3;
    logic [3*DW-1:0] od3;
    logic [2:0]    ol3, ov3;
`ifdef NOC_DEMUX_DROP_CNT_EN
    logic [15:0]   dc4, dc3;
`endif

    logic          o_rdy;
    logic [4*DW-1:0] o_d;
    logic [3:0]    o_l, o_v;

    always #5 clk = ~clk;

    noc_demux_1ton #(.DATA_W(DW), .NUM_OUT(4), .FIFO_DEPTH(D)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid && !use3), .in_ready(rdy4), .out_data(od4), .out_last(ol4),
        .out_valid(ov4), .out_ready(out_ready)
`ifdef NOC_DEMUX_DROP_CNT_EN
        , .drop_cnt(dc4)
`endif
    );

    noc_demux_1ton #(.DATA_W(DW), .NUM_OUT(3), .FIFO_DEPTH(D)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid && use3), .in_ready(rdy3), .out_data(od3), .out_last(ol3),
        .out_valid(ov3), .out_ready(out_ready[2:0])
`ifdef NOC_DEMUX_DROP_CNT_EN
        , .drop_cnt(dc3)
`endif
    );

    always_comb begin
        if (use3) begin
            o_rdy = rdy3;
            o_d   = {{DW{1'b0}}, od3};
            o_l   = {1'b0, ol3};
            o_v   = {1'b0, ov3};
        end else begin
            o_rdy = rdy4;
            o_d   = od4;
            o_l   = ol4;
            o_v   = ov4;
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: per-port queues of {last,data}; open_dest = port of the open packet (-1 none).
    logic [DW:0] mq [4][$];
    int          open_dest = -1;
    int          nports = 4;
    int          drops = 0;
    bit          last_acc;

    task automatic model_clear();
        for (int k = 0; k < 4; k++) mq[k].delete();
        open_dest = -1;
    endtask

    task automatic cycle();
        logic       exp_rdy;
        logic [3:0] pops;
        bit         ev;
        int         tgt;
        @(negedge clk);
        tgt = (open_dest >= 0) ? open_dest : int'(in_sel);
        if (tgt >= nports) exp_rdy = 1'b1;
        else               exp_rdy = (mq[tgt].size() < D);
        checks++;
        if (o_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b at %0t", o_rdy, exp_rdy, $time);
        end
        pops = '0;
        for (int k = 0; k < 4; k++) begin
            ev = (k < nports) && (mq[k].size() > 0);
            checks++;
            if (o_v[k] !== ev) begin
                errors++;
                $display("FAIL out_valid[%0d]: got %b expected %b at %0t", k, o_v[k], ev, $time);
            end
            if (ev) begin
                checks++;
                if ({o_l[k], o_d[k*DW +: DW]} !== mq[k][0]) begin
                    errors++;
                    $display("FAIL out_flit[%0d]: got %h expected %h at %0t", k,
                             {o_l[k], o_d[k*DW +: DW]}, mq[k][0], $time);
                end
                pops[k] = out_ready[k];
            end
        end
        last_acc = in_valid && exp_rdy;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (pops[k]) void'(mq[k].pop_front());
        end
        if (last_acc) begin
            if (tgt < nports) mq[tgt].push_back({in_last, in_data});
            else              drops++;
            open_dest = in_last ? -1 : tgt;
        end
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic last, input logic [DW-1:0] d,
                        output int ncyc);
        ncyc     = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_last  = last;
        in_data  = d;
        do begin
            cycle();
            ncyc++;
        end while (!last_acc && ncyc < 40);
        checks++;
        if (!last_acc) begin
            errors++;
            $display("FAIL send_timeout: accepted=0 required=1 after %0d cycles", ncyc);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_last = 1'b0;
        out_ready = 4'hF; use3 = 1'b0;
        #2;
        checks++;
        if ({rdy4, ov4, ol4} !== 9'b0 || od4 !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b l=%b d=%h expected all zero", rdy4, ov4, ol4, od4);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single_flit();
        int n;
        out_ready = 4'hF;
        send(2'd2, 1'b1, 32'hA5A5_0001, n);
        checks++;
        if (ov4 !== 4'b0100 || od4[2*DW +: DW] !== 32'hA5A5_0001 || ol4[2] !== 1'b1) begin
            errors++;
            $display("FAIL single_flit: got v=%b d=%h l=%b expected v=0100 d=a5a50001 l=1",
                     ov4, od4[2*DW +: DW], ol4[2]);
        end
        idle(2);
    endtask

    task automatic test_packet();
        int n;
        out_ready = 4'hF;
        send(2'd1, 1'b0, 32'h1000_0001, n);
        send(2'd3, 1'b0, 32'h1000_0002, n);
        send(2'd3, 1'b0, 32'h1000_0003, n);
        send(2'd3, 1'b1, 32'h1000_0004, n);
        send(2'd3, 1'b1, 32'h3000_0001, n);
        idle(3);
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 4'b0000;
        send(2'd0, 1'b0, 32'hB000_0001, n);
        send(2'd0, 1'b0, 32'hB000_0002, n);
        in_valid = 1'b1; in_sel = 2'd2; in_last = 1'b1; in_data = 32'hB000_0003;
        repeat (3) cycle();
        checks++;
        if (rdy4 !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %b expected 0 with port 0 full", rdy4);
        end
        out_ready = 4'hF;
        send(2'd2, 1'b1, 32'hB000_0003, n);
        idle(4);
    endtask

    task automatic test_parallel();
        int n;
        out_ready = 4'b1110;
        send(2'd0, 1'b1, 32'hC000_0001, n);
        send(2'd0, 1'b1, 32'hC000_0002, n);
        for (int i = 0; i < 3; i++) begin
            send(2'd1, (i == 2), 32'hD000_0000 + i, n);
            checks++;
            if (n != 1) begin
                errors++;
                $display("FAIL parallel_accept: got %0d cycles expected 1 for flit %0d", n, i);
            end
        end
        idle(3);
        out_ready = 4'hF;
        idle(4);
    endtask

    task automatic test_reset_mid_packet();
        int n;
        out_ready = 4'b0000;
        send(2'd1, 1'b0, 32'hE000_0001, n);
        send(2'd1, 1'b0, 32'hE000_0002, n);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ov4 !== 4'b0 || rdy4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b rdy=%b expected v=0000 rdy=0", ov4, rdy4);
        end
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 4'hF;
        idle(3);
        send(2'd0, 1'b1, 32'hE000_0003, n);
        checks++;
        if (ov4 !== 4'b0001 || od4[DW-1:0] !== 32'hE000_0003) begin
            errors++;
            $display("FAIL reset_mid_route: got v=%b d=%h expected v=0001 d=e0000003", ov4, od4[DW-1:0]);
        end
        idle(2);
    endtask

    task automatic test_random(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_last   = ($urandom_range(0, 2) == 0);
            in_data   = $urandom;
            out_ready = 4'($urandom);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 4'hF;
        idle(6);
    endtask

    task automatic test_drop();
        int n;
        use3 = 1'b1;
        nports = 3;
        model_clear();
        drops = 0;
        out_ready = 4'hF;
        send(2'd3, 1'b0, 32'hF000_0001, n);
        send(2'd0, 1'b1, 32'hF000_0002, n);
        idle(2);
        checks++;
        if (ov3 !== 3'b0 || drops != 2) begin
            errors++;
            $display("FAIL drop_silent: got v=%b model_drops=%0d expected v=000 drops=2", ov3, drops);
        end
`ifdef NOC_DEMUX_DROP_CNT_EN
        checks++;
        if (dc3 !== 16'd2) begin
            errors++;
            $display("FAIL drop_cnt: got %0d expected 2", dc3);
        end
`endif
        send(2'd2, 1'b1, 32'hF000_0003, n);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_packet();
        test_backpressure();
        test_parallel();
        test_reset_mid_packet();
        test_random(400);
        test_drop();
        test_random(300);
`ifdef NOC_DEMUX_DROP_CNT_EN
        checks++;
        if (dc3 !== 16'(drops)) begin
            errors++;
            $display("FAIL drop_cnt_random: got %0d expected %0d", dc3, drops);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
